sync_fifo: RTL and testbench

//   Single-clock FIFO built on an inferred 1-clk-latency dual-port RAM (write port + registered read port).

---
 rtl/sync_fifo.sv | 156 +++++++++++++++
 tb/tb_sync_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO over an inferred dual-port RAM with a registered read port.
// FWFT=1 adds a RAM-output stage and an output register so the head word is presented without rd_en.
module sync_fifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 256,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [WIDTH-1:0]      ram_q_r;
    logic [WIDTH-1:0]      rd_data_r;
    logic [ADDR_WIDTH-1:0] wptr_r;
    logic [ADDR_WIDTH-1:0] rptr_r;
    logic [CW-1:0]         count_r;
    logic                  ram_v_r;
    logic                  rd_valid_r;
    logic                  empty_r;
    logic                  full_r;
    logic                  aempty_r;
    logic                  afull_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  ram_re_s;
    logic                  out_take_s;
    logic                  out_load_s;
    logic                  out_v_next_s;
    logic                  ram_v_next_s;
    logic                  empty_next_s;
    logic [CW-1:0]         mem_words_s;
    logic [CW-1:0]         count_next_s;

    // Accept/reject decisions, prefetch pipeline control and next occupancy
    always_comb begin
        rd_acc_s     = 1'b0;
        out_take_s   = 1'b0;
        out_load_s   = 1'b0;
        ram_re_s     = 1'b0;
        out_v_next_s = 1'b0;
        ram_v_next_s = 1'b0;
        mem_words_s  = {CW{1'b0}};
        if (FWFT != 0) begin
            // Words still sitting in RAM slots: everything not already in the two register stages.
            // A word written at this edge is not counted yet, so prefetch never reads it the same edge.
            mem_words_s  = count_r - CW'(ram_v_r) - CW'(rd_valid_r);
            rd_acc_s     = rd_en && rd_valid_r;
            out_take_s   = !rd_valid_r || rd_acc_s;
            out_load_s   = out_take_s && ram_v_r;
            ram_re_s     = (!ram_v_r || out_take_s) && (mem_words_s != {CW{1'b0}});
            if (out_load_s) begin
                out_v_next_s = 1'b1;
            end else begin
                out_v_next_s = rd_valid_r && !rd_acc_s;
            end
            if (ram_re_s) begin
                ram_v_next_s = 1'b1;
            end else begin
                ram_v_next_s = ram_v_r && !out_load_s;
            end
        end else begin
            rd_acc_s     = rd_en && !empty_r;
            ram_re_s     = rd_acc_s;
            out_v_next_s = rd_acc_s;
        end

        wr_acc_s = wr_en && (!full_r || rd_acc_s);

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + 1'b1;
            2'b01:   count_next_s = count_r - 1'b1;
            default: count_next_s = count_r;
        endcase

        if (FWFT != 0) begin
            empty_next_s = !out_v_next_s;
        end else begin
            empty_next_s = (count_next_s == {CW{1'b0}});
        end
    end

    // RAM write port and registered prefetch read port; left unreset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst) mem_r[wptr_r] <= wr_data;
        if (ram_re_s) ram_q_r <= mem_r[rptr_r];
    end

    // Pointers, occupancy, flags and the output data register
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r      <= {ADDR_WIDTH{1'b0}};
            rptr_r      <= {ADDR_WIDTH{1'b0}};
            count_r     <= {CW{1'b0}};
            ram_v_r     <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= {WIDTH{1'b0}};
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            aempty_r    <= 1'b1;
            afull_r     <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) wptr_r <= wptr_r + 1'b1;
            if (ram_re_s) rptr_r <= rptr_r + 1'b1;
            count_r     <= count_next_s;
            ram_v_r     <= ram_v_next_s;
            rd_valid_r  <= out_v_next_s;
            empty_r     <= empty_next_s;
            full_r      <= (count_next_s == DEPTH_C);
            aempty_r    <= (count_next_s <= AEMPTY_C);
            afull_r     <= (count_next_s >= AFULL_C);
            overflow_r  <= wr_en && !wr_acc_s;
            underflow_r <= rd_en && !rd_acc_s;
            if (FWFT != 0) begin
                if (out_load_s) rd_data_r <= ram_q_r;
            end else begin
                if (rd_acc_s) rd_data_r <= mem_r[rptr_r];
            end
        end
    end

    assign rd_data      = rd_data_r;
    assign rd_valid     = rd_valid_r;
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_empty = aempty_r;
    assign almost_full  = afull_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: standard and FWFT instances share stimulus; a queue-based model checks both every cycle.
module tb_sync_fifo;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = 5;
    localparam int AF = 12;
    localparam int AE = 4;

    logic clk = 1'b0;
    logic rst, wr_en, rd_en;
    logic [W-1:0] wr_data;

    logic [W-1:0]  s_rd_data, f_rd_data;
    logic [CW-1:0] s_count, f_count;
    logic s_rd_valid, s_empty, s_full, s_aempty, s_afull, s_ovf, s_udf;
    logic f_rd_valid, f_empty, f_full, f_aempty, f_afull, f_ovf, f_udf;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Model state: index 0 = standard, 1 = FWFT
    int qd0[$];
    int qd1[$];
    int qw1[$];
    logic [7:0] m_rd [2];
    bit         m_rv [2];
    bit         m_ov [2];
    bit         m_un [2];

    typedef struct {
        logic r, w, rd;
        logic [7:0] wd;
        logic [19:0] exp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty), .full(s_full),
        .almost_empty(s_aempty), .almost_full(s_afull), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf));

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty), .full(f_full),
        .almost_empty(f_aempty), .almost_full(f_afull), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Packed {count, empty, full, aempty, afull, rd_valid, rd_data, ovf, udf}
    function automatic logic [19:0] pack(input int cnt, input logic emp, ful, ae, af, rv,
                                         input logic [7:0] rdd, input logic ov, un);
        return {5'(cnt), emp, ful, ae, af, rv, rdd, ov, un};
    endfunction

    function automatic vec_t mk(input logic r, w, rd, input logic [7:0] wd, input logic [19:0] e);
        vec_t v;
        v.r = r; v.w = w; v.rd = rd; v.wd = wd; v.exp = e;
        return v;
    endfunction

    // Reference behaviour: FIFO order from a queue; in FWFT a word is visible two edges after its write
    task automatic model_step();
        int sz;
        bit rd_ok, wr_ok;
        edge_n++;
        if (rst) begin
            qd0.delete();
            m_rd[0] = 8'h00; m_rv[0] = 1'b0; m_ov[0] = 1'b0; m_un[0] = 1'b0;
        end else begin
            sz    = qd0.size();
            rd_ok = rd_en && (sz > 0);
            wr_ok = wr_en && ((sz < D) || rd_ok);
            m_rv[0] = rd_ok;
            if (rd_ok) m_rd[0] = 8'(qd0.pop_front());
            if (wr_ok) qd0.push_back(int'(wr_data));
            m_ov[0] = wr_en && !wr_ok;
            m_un[0] = rd_en && !rd_ok;
        end
        if (rst) begin
            qd1.delete(); qw1.delete();
            m_rd[1] = 8'h00; m_rv[1] = 1'b0; m_ov[1] = 1'b0; m_un[1] = 1'b0;
        end else begin
            sz    = qd1.size();
            rd_ok = rd_en && m_rv[1];
            wr_ok = wr_en && ((sz < D) || rd_ok);
            if (rd_ok) begin
                void'(qd1.pop_front());
                void'(qw1.pop_front());
            end
            if (wr_ok) begin
                qd1.push_back(int'(wr_data));
                qw1.push_back(edge_n);
            end
            m_ov[1] = wr_en && !wr_ok;
            m_un[1] = rd_en && !rd_ok;
            m_rv[1] = 1'b0;
            if (qd1.size() > 0) begin
                if (qw1[0] + 2 <= edge_n) begin
                    m_rv[1] = 1'b1;
                    m_rd[1] = 8'(qd1[0]);
                end
            end
        end
    endtask

    task automatic check_model(input int m);
        int sz;
        logic [11:0] act, exp;
        logic [7:0] a_rd;
        bit bad;
        sz = (m == 0) ? qd0.size() : qd1.size();
        if (m == 0) begin
            act  = {s_count, s_empty, s_full, s_aempty, s_afull, s_rd_valid, s_ovf, s_udf};
            a_rd = s_rd_data;
            exp  = {5'(sz), sz == 0, sz == D, sz <= AE, sz >= AF, m_rv[0], m_ov[0], m_un[0]};
        end else begin
            act  = {f_count, f_empty, f_full, f_aempty, f_afull, f_rd_valid, f_ovf, f_udf};
            a_rd = f_rd_data;
            exp  = {5'(sz), !m_rv[1], sz == D, sz <= AE, sz >= AF, m_rv[1], m_ov[1], m_un[1]};
        end
        bad = (act !== exp);
        if ((m == 0 || m_rv[m]) && (a_rd !== m_rd[m])) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL model_%s edge=%0d flags got 0x%0h exp 0x%0h data got 0x%0h exp 0x%0h",
                     (m == 0) ? "std" : "fwft", edge_n, act, exp, a_rd, m_rd[m]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(0);
        check_model(1);
    endtask

    initial begin
        int got[$];
        int first_c, last_c, pw, pr;
        logic [19:0] act;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;

        // Directed vectors for the standard instance
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, pack(0, 1, 0, 1, 0, 0, 8'h00, 0, 0)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, pack(0, 1, 0, 1, 0, 0, 8'h00, 0, 1)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, pack(0, 1, 0, 1, 0, 0, 8'h00, 0, 0)));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'(i), pack(i, 0, 0, i <= 4, 0, 0, 8'h00, 0, 0)));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, pack(8 - i, i == 8, 0, (8 - i) <= 4, 0, 1, 8'(i), 0, 0)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, pack(0, 1, 0, 1, 0, 0, 8'h08, 0, 0)));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'(16 + i),
                             pack(i + 1, 0, (i + 1) == 16, (i + 1) <= 4, (i + 1) >= 12, 0, 8'h08, 0, 0)));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hEE, pack(16, 0, 1, 0, 1, 0, 8'h08, 1, 0)));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h77, pack(16, 0, 1, 0, 1, 1, 8'h10, 0, 0)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, pack(16, 0, 1, 0, 1, 0, 8'h10, 0, 0)));

        for (int k = 0; k < tbl.size(); k++) begin
            rst = tbl[k].r; wr_en = tbl[k].w; rd_en = tbl[k].rd; wr_data = tbl[k].wd;
            cycle();
            act = {s_count, s_empty, s_full, s_aempty, s_afull, s_rd_valid, s_rd_data, s_ovf, s_udf};
            chk($sformatf("vec%0d", k), 32'(act), 32'(tbl[k].exp));
        end

        // FWFT first-word latency: visible two edges after the write
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; cycle();
        rst = 1'b0; wr_en = 1'b1; wr_data = 8'hA5; cycle();
        wr_en = 1'b0;
        chk("fwft_valid_e0", 32'(f_rd_valid), 32'd0);
        chk("std_empty_e0", 32'(s_empty), 32'd0);
        cycle();
        chk("fwft_valid_e1", 32'(f_rd_valid), 32'd0);
        cycle();
        chk("fwft_valid_e2", 32'({f_rd_valid, f_rd_data}), 32'h1A5);

        // FWFT streaming of 40 words with rd_en held high
        rst = 1'b1; cycle();
        rst = 1'b0; rd_en = 1'b1;
        first_c = -1; last_c = -1;
        for (int c = 0; c < 46; c++) begin
            wr_en = (c < 40); wr_data = 8'(100 + c);
            cycle();
            if (f_rd_valid) begin
                got.push_back(int'(f_rd_data));
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        chk("stream_words", 32'(got.size()), 32'd40);
        chk("stream_span", 32'(last_c - first_c), 32'd39);
        for (int k = 0; k < got.size(); k++)
            if (got[k] != 100 + k) chk($sformatf("stream_data%0d", k), 32'(got[k]), 32'(100 + k));

        // Reset in the middle of a half-full FIFO
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(200 + i); cycle();
        end
        chk("half_count", 32'({s_count, f_count}), 32'({5'd8, 5'd8}));
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; cycle();
        chk("rst_std", 32'({s_count, s_empty, s_full, s_aempty, s_afull, s_rd_valid, s_rd_data, s_ovf, s_udf}),
            32'(pack(0, 1, 0, 1, 0, 0, 8'h00, 0, 0)));
        chk("rst_fwft", 32'({f_count, f_empty, f_full, f_aempty, f_afull, f_rd_valid, f_rd_data, f_ovf, f_udf}),
            32'(pack(0, 1, 0, 1, 0, 0, 8'h00, 0, 0)));
        rst = 1'b0; rd_en = 1'b0; wr_data = 8'h3C; cycle();
        wr_en = 1'b0; cycle();
        rd_en = 1'b1; cycle();
        chk("post_rst_std", 32'({s_rd_valid, s_rd_data}), 32'h13C);
        chk("post_rst_fwft", 32'({f_rd_valid, f_rd_data}), 32'h13C);
        cycle();
        chk("post_rst_drained", 32'({s_rd_valid, s_count, f_rd_valid, f_count}), 32'd0);
        rd_en = 1'b0;

        // Randomised traffic with occasional reset, checked by the model every cycle
        pw = 50; pr = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 1000 == 0) begin
                pw = $urandom_range(15, 85);
                pr = $urandom_range(15, 85);
            end
            rst     = ($urandom_range(0, 999) == 0);
            wr_en   = ($urandom_range(0, 99) < pw);
            rd_en   = ($urandom_range(0, 99) < pr);
            wr_data = 8'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
